// File: rtl/fifo_pkg.sv
// Shared defaults and types for the synchronous FIFO block.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 16;

    typedef logic [FIFO_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately left out of reset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A same-address read and write returns the old word, which is the
    // oldest entry when a full FIFO reads and writes together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/top.sv
// Single-clock FIFO: pointer/flag control around one fifo_mem instance.
module top
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                wr_acc;
    logic                rd_acc;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    always_comb begin
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_acc);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: queue-based reference model, decoupled monitor.
module tb_top;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    typedef struct {
        word_t d;
        logic  e;
        logic  f;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  wr_en;
    logic  rd_en;
    word_t data_in;
    word_t data_out;
    logic  full;
    logic  empty;

    int unsigned checks = 0;
    int unsigned errors = 0;

    word_t model[$];
    word_t m_out;
    exp_t  exp_q[$];
    word_t first16[16];

    always #5 clk = ~clk;

    top #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    // Drive one cycle of stimulus and record what the outputs must be after the edge.
    task automatic step(input logic w, input logic r, input logic rs, input word_t d);
        logic rd_ok;
        logic wr_ok;
        wr_en   = w;
        rd_en   = r;
        rst     = rs;
        data_in = d;
        if (rs) begin
            model.delete();
            m_out = '0;
        end else begin
            rd_ok = r && (model.size() > 0);
            wr_ok = w && ((model.size() < DEPTH) || rd_ok);
            if (rd_ok) m_out = model.pop_front();
            if (wr_ok) model.push_back(d);
        end
        exp_q.push_back('{d: m_out, e: (model.size() == 0), f: (model.size() == DEPTH)});
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new output state; compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (data_out !== x.d) begin
                    errors++;
                    $display("FAIL data_out @%0t: got %h expected %h", $time, data_out, x.d);
                end
                checks++;
                if (empty !== x.e) begin
                    errors++;
                    $display("FAIL empty @%0t: got %b expected %b", $time, empty, x.e);
                end
                checks++;
                if (full !== x.f) begin
                    errors++;
                    $display("FAIL full @%0t: got %b expected %b", $time, full, x.f);
                end
            end
        end
    end

    initial begin
        word_t five[5];
        five[0] = 32'h12153524;
        five[1] = 32'hC0895E81;
        five[2] = 32'h8484D609;
        five[3] = 32'hB1F05663;
        five[4] = 32'h06B97B0D;
        m_out   = '0;

        // 1: reset then idle
        step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);

        // 2: five writes then five reads
        for (int i = 0; i < 5; i++) step(1, 0, 0, five[i]);
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
        step(0, 0, 0, '0);

        // 3: fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) begin
            first16[i] = $urandom;
            step(1, 0, 0, first16[i]);
        end
        step(1, 0, 0, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0);

        // 4: reads while empty
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);

        // 5: simultaneous read/write when full, then when empty
        for (int i = 0; i < 16; i++) step(1, 0, 0, $urandom);
        step(1, 1, 0, 32'h5A5A0001);
        step(1, 1, 0, 32'h5A5A0002);
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0);
        step(1, 1, 0, 32'h0BADF00D);
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);

        // 6: reset mid-operation discards queued data
        for (int i = 0; i < 3; i++) step(1, 0, 0, $urandom);
        step(0, 1, 0, '0);
        step(0, 0, 1, '0);
        step(1, 0, 0, 32'hA5A5A5A5);
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 99) < 55),
                 logic'($urandom_range(0, 99) < 45),
                 logic'($urandom_range(0, 99) < 2),
                 $urandom);
        end
        step(0, 0, 0, '0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
